// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
// Time-multiplexed scan controller for an N-digit seven-segment display.
// One digit is serviced per slot of REFRESH_DIV cycles. Each slot starts with
// BLANK_CYCLES dark cycles to avoid ghosting. Leading zeros can be suppressed.
// CPU writes land in a pending buffer and are committed only at a frame
// boundary, so the display never shows a half-updated value.
// Every output is registered and is computed from the next-state values, so it
// changes on the same edge as the state it describes.

module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    lz_en,
  output logic [3:0]              code,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    blank,
  output logic                    frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
  localparam bit            HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_t;

  // Scan and buffer state.
  // 'started' is clear only between reset release and the first edge, which
  // makes that first edge open frame 0 at slot 0, count 0.
  logic                    started;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] display;
  logic [4*NUM_DIGITS-1:0] pending;
  logic                    pend_valid;

  // Next-state values.
  logic [CW-1:0]           cnt_n;
  logic [IW-1:0]           idx_n;
  logic                    wrap_n;
  logic                    commit;
  logic [4*NUM_DIGITS-1:0] display_n;
  phase_t                  phase_n;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    all_zero;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   dig_en_n;
  logic [3:0]              code_n;

  // Next counters, frame wrap, commit, phase and the digit enable for the next cycle
  always_comb begin
    cnt_n    = cnt;
    idx_n    = idx;
    wrap_n   = 1'b0;
    supp     = '0;
    all_zero = 1'b1;

    if (!started) begin
      cnt_n  = '0;
      idx_n  = '0;
      wrap_n = 1'b1;
    end else if (cnt == CNT_MAX) begin
      cnt_n = '0;
      if (idx == IDX_MAX) begin
        idx_n  = '0;
        wrap_n = 1'b1;
      end else begin
        idx_n = idx + 1'b1;
      end
    end else begin
      cnt_n = cnt + 1'b1;
    end

    // The commit takes the pending value held before this edge; a load on the
    // same edge stays pending for the next frame.
    commit    = wrap_n && pend_valid;
    display_n = commit ? pending : display;

    phase_n = (HAS_BLANK && (cnt_n < BLANK_LIM)) ? PH_BLANK : PH_SHOW;

    // Walk from the top digit down; a digit is a leading zero while it and
    // everything above it is zero. Digit 0 always stays lit.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (display_n[4*k +: 4] == 4'd0);
      if (k != 0) begin
        supp[k] = lz_en && all_zero;
      end
    end

    code_n   = display_n[{idx_n, 2'b00} +: 4];
    lit      = (phase_n == PH_SHOW) && !supp[idx_n];
    dig_en_n = lit ? (NUM_DIGITS'(1) << idx_n) : '0;
  end

  // Register the scan state, the buffers and all outputs together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      started     <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      display     <= '0;
      pending     <= '0;
      pend_valid  <= 1'b0;
      code        <= 4'd0;
      dig_en      <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      started     <= 1'b1;
      cnt         <= cnt_n;
      idx         <= idx_n;
      display     <= display_n;
      if (load) begin
        pending    <= data_in;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      code        <= code_n;
      dig_en      <= dig_en_n;
      blank       <= ~|dig_en_n;
      frame_start <= wrap_n;
    end
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-segment seven-segment display. It shares one 4-bit-to-seven-segment decoder among all digits. Each cycle it presents one digit's 4-bit code and drives a one-hot digit enable. It inserts a dark interval between digits to prevent ghosting, optionally suppresses leading zeros, and double-buffers CPU-written values so an update never tears mid-frame. It sits between the microcomputer's output-port register and the board display.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clock cycles per digit slot (>=2)
BLANK_CYCLES, 500, dark cycles at the start of each slot (0 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  single-cycle strobe; capture data_in into pending buffer
data_in  input  4*NUM_DIGITS  digit codes; digit 0 = bits [3:0] (rightmost), digit k = [4k+3:4k]
lz_en  input  1  1 = suppress leading zero digits
code  output  4  code for decoder, current digit
dig_en  output  NUM_DIGITS  one-hot active-high digit enable, all-zero when dark
blank  output  1  1 when no digit is lit in this cycle
frame_start  output  1  one-cycle pulse, first cycle of slot 0

Behaviour:
- Reset (async, immediate): slot counter 0, digit index 0, display reg 0, pending reg 0, pend_valid 0, code 0, dig_en 0, blank 1, frame_start 0.
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..NUM_DIGITS-1), phase BLANK/SHOW.
  - BLANK while cnt < BLANK_CYCLES; SHOW otherwise. Skip BLANK if BLANK_CYCLES=0.
  - When cnt = REFRESH_DIV-1: cnt goes to 0 and idx increments, wrapping from NUM_DIGITS-1 to 0.
- Frame = NUM_DIGITS*REFRESH_DIV cycles. The first frame starts on the first edge after reset release.
- All outputs are registered and update on the same edge as the state they describe. No combinational path from inputs to outputs.
- code = display nibble idx, in both phases.
- dig_en[idx] = 1 only in SHOW when the digit is not suppressed. Otherwise all zero. blank = ~|dig_en.
- Leading-zero suppression (lz_en=1): digit k is suppressed if it and every higher digit equal 0. Digit 0 is never suppressed. lz_en is sampled each cycle.
- Codes 10..15 are non-zero and are never suppressed; they pass through to the decoder.
- Load: on load=1, pending <= data_in and pend_valid <= 1. Back-to-back loads overwrite; the last one wins.
- Commit: on the edge where idx wraps to 0, if pend_valid, display <= pending and pend_valid <= 0.
  - The commit uses the pending value held before this edge.
  - A load on the wrap edge is kept in pending and committed at the following frame.
- frame_start = 1 for the first cycle of slot 0 of every frame, including the first after reset.
- Reset mid-frame: all outputs drop to reset values immediately, and buffered data is discarded.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, so a frame is 32 cycles.
1. Assert rst, then hold -> dig_en=0000, blank=1, code=0. After release, frame_start pulses at cycle 0 and again at cycle 32.
2. load with data_in=16'h1234 at cycle 3, lz_en=0 -> frame 0 shows code 0 on digit 0. From cycle 32:
   - cycles 32-33: dig_en=0000.
   - cycles 34-39: dig_en=0001, code=4.
   - cycles 42-47: dig_en=0010, code=3.
   - digits 2 and 3 follow with codes 2 and 1.
3. Display 16'h0050 with lz_en=1 -> digits 3 and 2 are never enabled, digit 1 lit with code 5, digit 0 lit with code 0. Display 16'h0000 -> only dig_en=0001 is ever lit.
4. load 16'hAAAA then load 16'h5B5B in the same frame -> the next frame shows only 5/B, and A never appears. Load 16'h9999 on the last cycle of the frame -> the new frame still shows the old value, and 9s appear one frame later.
5. Assert rst during the SHOW phase of digit 2 -> on the same edge dig_en=0000, blank=1. After release the display reads all zeros (pending discarded).
6. Check dig_en over 4 full frames -> at most one bit set in any cycle, and exactly BLANK_CYCLES dark cycles at each slot start.
